// File: rtl/jtcps1_sdram_pkg.sv
// Shared types for the CPS SDRAM bank scheduler: command record, FSM states,
// bank indices and a one-hot helper.
package jtcps1_sdram_pkg;

  localparam int ADDR_W = 23;

  localparam logic [1:0] BANK0 = 2'd0;
  localparam logic [1:0] BANK1 = 2'd1;
  localparam logic [1:0] BANK2 = 2'd2;
  localparam logic [1:0] BANK3 = 2'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  typedef struct packed {
    logic [1:0]        ba;
    logic [ADDR_W-1:0] addr;
    logic              wr;
    logic              rfsh;
    logic [15:0]       din;
    logic [1:0]        mask;
  } cmd_t;

  function automatic logic [3:0] bank_onehot(input logic [1:0] bank);
    return 4'b0001 << bank;
  endfunction

endpackage

// File: rtl/jtcps1_bank_tagq.sv
// Two-entry FIFO of bank tags for commands accepted by the SDRAM controller
// whose data phase has not completed yet.
module jtcps1_bank_tagq (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [1:0] push_tag,
  input  logic       pop,
  output logic [1:0] head,
  output logic       full,
  output logic       empty
);

  logic [1:0] tags [2];
  logic       wptr, rptr;
  logic [1:0] count;
  logic       do_push, do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = tags[rptr];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (do_push) wptr <= ~wptr;
      if (do_pop)  rptr <= ~rptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: tag storage is left unreset; count gates every use of head.
  always_ff @(posedge clk) begin
    if (do_push) tags[wptr] <= push_tag;
  end

endmodule

// File: rtl/jtcps1_bank_sched.sv
// Round-robin scheduler from four CPS bank slot managers to one SDRAM controller.
// Define JTCPS1_RFSH_EN to build the auto-refresh scheduler.
module jtcps1_bank_sched
  import jtcps1_sdram_pkg::*;
#(
  parameter int SDRAMW      = 23,
  parameter int RFSH_PERIOD = 750,
  parameter int RFSH_MAX    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SDRAMW-1:0] ba0_addr,
  input  logic [SDRAMW-1:0] ba1_addr,
  input  logic [SDRAMW-1:0] ba2_addr,
  input  logic [SDRAMW-1:0] ba3_addr,
  input  logic [3:0]        ba_rd,
  input  logic              ba_wr,
  input  logic [15:0]       ba0_din,
  input  logic [1:0]        ba0_din_m,
  output logic [3:0]        ba_ack,
  output logic [3:0]        ba_dst,
  output logic [3:0]        ba_rdy,
  output logic              cmd_req,
  output logic [1:0]        cmd_ba,
  output logic [SDRAMW-1:0] cmd_addr,
  output logic              cmd_wr,
  output logic              cmd_rfsh,
  output logic [15:0]       cmd_din,
  output logic [1:0]        cmd_mask,
  input  logic              cmd_ack,
  input  logic              sd_dst,
  input  logic              sd_rdy
);

  state_t            state, state_d;
  cmd_t              cmd_q, cmd_d;
  logic [1:0]        rr, rr_d;
  logic [3:0]        ack_mask;
  logic [3:0]        elig;
  logic              found;
  logic [1:0]        win;
  logic              rfsh_go;
  logic              accepted;
  logic [1:0]        q_head;
  logic              q_full, q_empty;
  logic [SDRAMW-1:0] ba_addr [4];

  assign ba_addr[0] = ba0_addr;
  assign ba_addr[1] = ba1_addr;
  assign ba_addr[2] = ba2_addr;
  assign ba_addr[3] = ba3_addr;

  assign accepted = (state == ISSUE) && cmd_ack;
  assign ba_ack   = (accepted && !cmd_q.rfsh) ? bank_onehot(cmd_q.ba) : 4'b0000;
  assign ba_dst   = (sd_dst && !q_empty) ? bank_onehot(q_head) : 4'b0000;
  assign ba_rdy   = (sd_rdy && !q_empty) ? bank_onehot(q_head) : 4'b0000;

  assign cmd_req  = (state == ISSUE);
  assign cmd_ba   = cmd_q.ba;
  assign cmd_addr = SDRAMW'(cmd_q.addr);
  assign cmd_wr   = cmd_q.wr;
  assign cmd_din  = cmd_q.din;
  assign cmd_mask = cmd_q.mask;

  jtcps1_bank_tagq u_tagq (
    .clk      (clk),
    .rst      (rst),
    .push     (accepted && !cmd_q.rfsh),
    .push_tag (cmd_q.ba),
    .pop      (sd_rdy),
    .head     (q_head),
    .full     (q_full),
    .empty    (q_empty)
  );

  // The bank just acked may still show its request for a cycle; keep it out.
  assign elig = {ba_rd[3:1], ba_rd[0] | ba_wr} & ~ack_mask & {4{~q_full}};

  always_comb begin : arb
    logic [1:0] idx;
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    found = 1'b0;
    win   = rr;
    idx   = rr;
    for (int i = 0; i < 4; i++) begin
      idx = rr + 2'(i);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

`ifdef JTCPS1_RFSH_EN
  localparam int CNT_W = $clog2(RFSH_PERIOD);

  logic [CNT_W-1:0] rfsh_cnt;
  logic [1:0]       rfsh_pend;
  logic             rfsh_wrap, rfsh_done;

  assign rfsh_wrap = (rfsh_cnt == CNT_W'(RFSH_PERIOD - 1));
  assign rfsh_done = accepted && cmd_q.rfsh;
  assign rfsh_go   = (int'(rfsh_pend) >= RFSH_MAX) || (!found && rfsh_pend != 2'd0);
  assign cmd_rfsh  = cmd_q.rfsh;

  always_ff @(posedge clk) begin
    if (rst) begin
      rfsh_cnt  <= '0;
      rfsh_pend <= 2'd0;
    end else begin
      rfsh_cnt <= rfsh_wrap ? '0 : rfsh_cnt + 1'b1;
      if (rfsh_wrap && !rfsh_done && rfsh_pend != 2'd3)
        rfsh_pend <= rfsh_pend + 2'd1;
      else if (!rfsh_wrap && rfsh_done)
        rfsh_pend <= rfsh_pend - 2'd1;
    end
  end
`else
  assign rfsh_go  = 1'b0;
  assign cmd_rfsh = 1'b0;
`endif

  always_comb begin
    state_d = state;
    cmd_d   = cmd_q;
    rr_d    = rr;
    case (state)
      IDLE: begin
        if (rfsh_go) begin
          cmd_d      = '0;
          cmd_d.rfsh = 1'b1;
          state_d    = ISSUE;
        end else if (found) begin
          cmd_d.ba   = win;
          cmd_d.addr = ADDR_W'(ba_addr[win]);
          cmd_d.rfsh = 1'b0;
          cmd_d.wr   = (win == BANK0) && ba_wr;
          cmd_d.din  = cmd_d.wr ? ba0_din   : 16'h0000;
          cmd_d.mask = cmd_d.wr ? ba0_din_m : 2'b00;
          rr_d       = win + 2'd1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (cmd_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cmd_q    <= '0;
      rr       <= 2'd0;
      ack_mask <= 4'b0000;
    end else begin
      state    <= state_d;
      cmd_q    <= cmd_d;
      rr       <= rr_d;
      ack_mask <= ba_ack;
    end
  end

endmodule
